// File: rtl/mem_sequencer.sv
// mem_sequencer: walks one instruction through the shared single-port RAM:
// fetch at pc, optional data access, then a one-cycle PC write enable.
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   pc, halt, dREN, dWEN       fetch address and decoded controls
//   daddr, dstore              data access address / write data
//   instr, dload               registered fetch / load results
//   pcWEN, commit, halted      sequencing status
//   bus_err                    sticky error flag
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload,
//   ram_ready                  RAM request/response
// Optional feature: define MEM_SEQ_TIMEOUT_EN to bound every RAM wait to
// TIMEOUT cycles; an expired wait sets bus_err and halts.
module mem_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc,
    input  logic        halt,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] instr,
    output logic [31:0] dload,
    output logic        pcWEN,
    output logic        commit,
    output logic        halted,
    output logic        bus_err,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, DATA, COMMIT, HALT
    } state_t;

    state_t state, state_n;
    logic   err_set;
    logic   timeout;

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wcnt;
    logic          waiting;

    // Counter is zero whenever we are not stalled, so it is already
    // clear on entry to FETCH or DATA.
    assign waiting = ((state == FETCH) || (state == DATA)) && !ram_ready;
    // Fires on the TIMEOUT-th consecutive cycle without ram_ready.
    assign timeout = waiting && (wcnt == LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            wcnt <= '0;
        else if (waiting)
            wcnt <= wcnt + CW'(1);
        else
            wcnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        err_set  = 1'b0;
        unique case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                ramREN  = 1'b1;
                ramaddr = pc;
                if (timeout) begin
                    state_n = HALT;
                    err_set = 1'b1;
                end else if (ram_ready) begin
                    state_n = DECODE;
                end
            end
            DECODE: begin
                if (halt) begin
                    state_n = HALT;
                end else if (dREN || dWEN) begin
                    state_n = DATA;
                    err_set = dREN && dWEN;
                end else begin
                    state_n = COMMIT;
                end
            end
            DATA: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                // A conflicting request performs the write only.
                ramREN   = dREN && !dWEN;
                ramstore = dstore;
                if (timeout) begin
                    state_n = HALT;
                    err_set = 1'b1;
                end else if (ram_ready) begin
                    state_n = COMMIT;
                end
            end
            COMMIT: state_n = FETCH;
            HALT:   state_n = HALT;
            default: state_n = IDLE;
        endcase
    end

    assign pcWEN  = (state == COMMIT);
    assign commit = pcWEN;
    assign halted = (state == HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr   <= '0;
            dload   <= '0;
            bus_err <= 1'b0;
        end else begin
            if ((state == FETCH) && ram_ready)
                instr <= ramload;
            if ((state == DATA) && ram_ready && dREN && !dWEN)
                dload <= ramload;
            if (err_set)
                bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: scenario tasks for mem_sequencer with a queue of
// expected instruction / load values checked when the DUT presents them.
module tb_mem_sequencer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pc;
    logic        halt, dREN, dWEN;
    logic [31:0] daddr, dstore;
    logic [31:0] instr, dload;
    logic        pcWEN, commit, halted, bus_err;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] model_dload;

    always #5 CLK = ~CLK;

    mem_sequencer #(.TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST), .pc(pc), .halt(halt),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .instr(instr), .dload(dload), .pcWEN(pcWEN), .commit(commit),
        .halted(halted), .bus_err(bus_err), .ramREN(ramREN),
        .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready)
    );

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Leaves the bench at the negedge of cycle 1 (IDLE) after release.
    task automatic test_reset;
        nRST = 1'b0; halt = 0; dREN = 0; dWEN = 0;
        pc = 32'h40; daddr = 0; dstore = 0;
        ramload = 0; ram_ready = 0;
        model_dload = 0;
        repeat (2) @(negedge CLK);
        total++;
        if ({pcWEN, commit, halted, bus_err, ramREN, ramWEN} !== 6'b0)
            $display("FAIL reset_ctl: got %b want 000000",
                     {pcWEN, commit, halted, bus_err, ramREN, ramWEN});
        else passed++;
        total++;
        if ({instr, dload, ramaddr, ramstore} !== 128'b0)
            $display("FAIL reset_data: instr=%h dload=%h addr=%h st=%h want 0",
                     instr, dload, ramaddr, ramstore);
        else passed++;
        nRST = 1'b1;
        total++;
        if (ramREN !== 1'b0)
            $display("FAIL idle_cycle1: ramREN=%b want 0", ramREN);
        else passed++;
    endtask

    task automatic test_fetch;
        ramload = 32'h20; ram_ready = 1;
        exp_q.push_back(32'h20);
        tick;
        total++;
        if (ramREN !== 1'b1 || ramaddr !== pc)
            $display("FAIL fetch_c2: ramREN=%b addr=%h want 1 %h",
                     ramREN, ramaddr, pc);
        else passed++;
        tick;
        exp_v = exp_q.pop_front();
        total++;
        if (instr !== exp_v || pcWEN !== 1'b0)
            $display("FAIL decode_c3: instr=%h pcWEN=%b want %h 0",
                     instr, pcWEN, exp_v);
        else passed++;
        tick;
        total++;
        if (pcWEN !== 1'b1 || commit !== 1'b1)
            $display("FAIL commit_c4: pcWEN=%b commit=%b want 1 1",
                     pcWEN, commit);
        else passed++;
        pc = pc + 4;
        tick;
        total++;
        if (pcWEN !== 1'b0 || ramREN !== 1'b1 || ramaddr !== 32'h44)
            $display("FAIL refetch_c5: pcWEN=%b REN=%b addr=%h want 0 1 44",
                     pcWEN, ramREN, ramaddr);
        else passed++;
    endtask

    task automatic test_load;
        ramload = 32'h3; ram_ready = 1;
        exp_q.push_back(32'h3);
        tick;
        exp_v = exp_q.pop_front();
        total++;
        if (instr !== exp_v)
            $display("FAIL load_instr: got %h want %h", instr, exp_v);
        else passed++;
        dREN = 1; daddr = 32'h100; ram_ready = 0;
        tick;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ramREN !== 1'b1 || ramWEN !== 1'b0 ||
                ramaddr !== 32'h100 || pcWEN !== 1'b0)
                $display("FAIL load_wait%0d: REN=%b WEN=%b addr=%h pcWEN=%b",
                         i, ramREN, ramWEN, ramaddr, pcWEN);
            else passed++;
            if (i == 2) begin
                ramload = 32'hDEADBEEF; ram_ready = 1;
                exp_q.push_back(32'hDEADBEEF);
                model_dload = 32'hDEADBEEF;
            end else begin
                ramload = 32'hBAD0_0000 + i; ram_ready = 0;
            end
            tick;
        end
        exp_v = exp_q.pop_front();
        total++;
        if (dload !== exp_v || pcWEN !== 1'b1)
            $display("FAIL load_commit: dload=%h pcWEN=%b want %h 1",
                     dload, pcWEN, exp_v);
        else passed++;
        dREN = 0; pc = pc + 4;
        tick;
        total++;
        if (pcWEN !== 1'b0 || ramREN !== 1'b1 || ramaddr !== pc)
            $display("FAIL load_next: pcWEN=%b REN=%b addr=%h want 0 1 %h",
                     pcWEN, ramREN, ramaddr, pc);
        else passed++;
    endtask

    task automatic test_store;
        ramload = 32'h5; ram_ready = 1;
        exp_q.push_back(32'h5);
        tick;
        exp_v = exp_q.pop_front();
        total++;
        if (instr !== exp_v)
            $display("FAIL store_instr: got %h want %h", instr, exp_v);
        else passed++;
        dWEN = 1; dstore = 32'h12345678; daddr = 32'h200;
        ramload = 32'hFFFF_FFFF;
        tick;
        total++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 ||
            ramstore !== 32'h12345678 || ramaddr !== 32'h200)
            $display("FAIL store_data: WEN=%b REN=%b st=%h addr=%h",
                     ramWEN, ramREN, ramstore, ramaddr);
        else passed++;
        tick;
        total++;
        if (dload !== model_dload || pcWEN !== 1'b1 || bus_err !== 1'b0)
            $display("FAIL store_commit: dload=%h pcWEN=%b err=%b want %h 1 0",
                     dload, pcWEN, bus_err, model_dload);
        else passed++;
        dWEN = 0; pc = pc + 4;
        tick;
    endtask

    task automatic test_conflict;
        ramload = 32'h6; ram_ready = 1;
        exp_q.push_back(32'h6);
        tick;
        exp_v = exp_q.pop_front();
        total++;
        if (instr !== exp_v)
            $display("FAIL conf_instr: got %h want %h", instr, exp_v);
        else passed++;
        dREN = 1; dWEN = 1; dstore = 32'hCAFEF00D;
        ramload = 32'h1111_1111;
        tick;
        total++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hCAFEF00D)
            $display("FAIL conf_data: WEN=%b REN=%b st=%h want 1 0 cafef00d",
                     ramWEN, ramREN, ramstore);
        else passed++;
        tick;
        total++;
        if (bus_err !== 1'b1 || dload !== model_dload || pcWEN !== 1'b1)
            $display("FAIL conf_commit: err=%b dload=%h pcWEN=%b want 1 %h 1",
                     bus_err, dload, pcWEN, model_dload);
        else passed++;
        dREN = 0; dWEN = 0; pc = pc + 4;
        tick;
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            ramload = $urandom; ram_ready = 1;
            exp_q.push_back(ramload);
            tick;
            exp_v = exp_q.pop_front();
            total++;
            if (instr !== exp_v)
                $display("FAIL b2b_instr%0d: got %h want %h", k, instr, exp_v);
            else passed++;
            tick;
            total++;
            if (pcWEN !== 1'b1)
                $display("FAIL b2b_commit%0d: pcWEN=%b want 1", k, pcWEN);
            else passed++;
            pc = pc + 4;
            tick;
            total++;
            if (ramREN !== 1'b1 || ramaddr !== pc || pcWEN !== 1'b0)
                $display("FAIL b2b_fetch%0d: REN=%b addr=%h pcWEN=%b want %h",
                         k, ramREN, ramaddr, pcWEN, pc);
            else passed++;
        end
        total++;
        if (bus_err !== 1'b1)
            $display("FAIL err_sticky: bus_err=%b want 1", bus_err);
        else passed++;
    endtask

    task automatic test_halt;
        ramload = 32'hFC00_0000; ram_ready = 1;
        exp_q.push_back(32'hFC00_0000);
        tick;
        exp_v = exp_q.pop_front();
        total++;
        if (instr !== exp_v)
            $display("FAIL halt_instr: got %h want %h", instr, exp_v);
        else passed++;
        halt = 1;
        tick;
        halt = 0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (halted !== 1'b1 || pcWEN !== 1'b0 ||
                ramREN !== 1'b0 || ramWEN !== 1'b0)
                $display("FAIL halt_c%0d: halted=%b pcWEN=%b REN=%b WEN=%b",
                         i, halted, pcWEN, ramREN, ramWEN);
            else passed++;
            ram_ready = i[0];
            tick;
        end
    endtask

    task automatic test_reset_mid;
        nRST = 0;
        @(negedge CLK);
        nRST = 1; ram_ready = 0; pc = 32'h40;
        tick;
        tick;
        total++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40)
            $display("FAIL mid_wait: REN=%b addr=%h want 1 40",
                     ramREN, ramaddr);
        else passed++;
        #2 nRST = 0;
        #1;
        total++;
        if ({ramREN, ramWEN, pcWEN, halted, bus_err} !== 5'b0 ||
            instr !== 32'h0 || ramaddr !== 32'h0)
            $display("FAIL mid_async: ctl=%b instr=%h addr=%h want 0",
                     {ramREN, ramWEN, pcWEN, halted, bus_err}, instr, ramaddr);
        else passed++;
        @(negedge CLK);
        nRST = 1; ram_ready = 1; ramload = 32'h77;
        exp_q.push_back(32'h77);
        total++;
        if (ramREN !== 1'b0 || pcWEN !== 1'b0)
            $display("FAIL mid_idle: REN=%b pcWEN=%b want 0 0", ramREN, pcWEN);
        else passed++;
        tick;
        total++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || pcWEN !== 1'b0)
            $display("FAIL mid_refetch: REN=%b addr=%h pcWEN=%b want 1 40 0",
                     ramREN, ramaddr, pcWEN);
        else passed++;
        tick;
        exp_v = exp_q.pop_front();
        total++;
        if (instr !== exp_v || pcWEN !== 1'b0)
            $display("FAIL mid_decode: instr=%h pcWEN=%b want %h 0",
                     instr, pcWEN, exp_v);
        else passed++;
        tick;
        total++;
        if (pcWEN !== 1'b1)
            $display("FAIL mid_commit: pcWEN=%b want 1", pcWEN);
        else passed++;
    endtask

`ifdef MEM_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        nRST = 0; ram_ready = 0;
        @(negedge CLK);
        nRST = 1;
        tick;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ramREN !== 1'b1 || halted !== 1'b0)
                $display("FAIL to_wait%0d: REN=%b halted=%b want 1 0",
                         i, ramREN, halted);
            else passed++;
            tick;
        end
        total++;
        if (halted !== 1'b1 || bus_err !== 1'b1 ||
            ramREN !== 1'b0 || pcWEN !== 1'b0)
            $display("FAIL to_expire: halted=%b err=%b REN=%b pcWEN=%b",
                     halted, bus_err, ramREN, pcWEN);
        else passed++;
        nRST = 0;
        @(negedge CLK);
        nRST = 1;
        tick;
        for (int i = 0; i < 4; i++) begin
            ram_ready = (i == 3);
            ramload = 32'h99;
            if (i == 3) exp_q.push_back(32'h99);
            tick;
        end
        exp_v = exp_q.pop_front();
        total++;
        if (instr !== exp_v || halted !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL to_late_ok: instr=%h halted=%b err=%b want %h 0 0",
                     instr, halted, bus_err, exp_v);
        else passed++;
    endtask
`endif

    initial begin
        test_reset;
        test_fetch;
        test_load;
        test_store;
        test_conflict;
        test_back_to_back;
        test_halt;
        test_reset_mid;
`ifdef MEM_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Sequences one instruction through the shared single-port RAM: it fetches the instruction at the current PC and, when required, performs one data access. It then commits the instruction by pulsing the program counter write enable. It sits between the program counter, the decode/datapath logic and the RAM. It is the only block that may assert the PC write enable or drive RAM requests.

## Interface

Parameters:

- TIMEOUT, 255: maximum number of cycles to wait for `ram_ready` in one access. Used only when the feature in Configuration is enabled.

Ports:

- CLK, input, 1: clock; all state updates on its rising edge.
- nRST, input, 1: reset, asynchronous, active-low.
- pc, input, 32: current PC value (fetch address).
- halt, input, 1: decoded HALT instruction; sampled in DECODE only.
- dREN, input, 1: decoded data read request; sampled in DECODE, held by the datapath through DATA.
- dWEN, input, 1: decoded data write request; sampled in DECODE, held by the datapath through DATA.
- daddr, input, 32: data address; must be stable during DATA.
- dstore, input, 32: write data; must be stable during DATA.
- instr, output, 32: registered fetched instruction.
- dload, output, 32: registered data read result.
- pcWEN, output, 1: PC write enable; one-cycle pulse per committed instruction.
- commit, output, 1: equals `pcWEN`; qualifies register-file writes.
- halted, output, 1: high in HALT.
- bus_err, output, 1: sticky error flag.
- ramREN, output, 1: RAM read request.
- ramWEN, output, 1: RAM write request.
- ramaddr, output, 32: RAM address.
- ramstore, output, 32: RAM write data.
- ramload, input, 32: RAM read data; valid when `ram_ready` is high.
- ram_ready, input, 1: RAM completes the current request this cycle.

## Operation

- Reset values: state IDLE; `instr`, `dload` = 0; `pcWEN`, `commit`, `halted`, `bus_err` = 0; `ramREN`, `ramWEN` = 0; `ramaddr`, `ramstore` = 0.
- RAM outputs are Moore functions of the state, plus `pc`/`daddr`/`dstore` as address and data sources.

State machine:

- IDLE: no request. Next state is FETCH unconditionally.
- FETCH: `ramREN`=1, `ramaddr`=`pc`.
  - On `ram_ready`: `instr` <= `ramload`; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: no RAM request. Sample the decode inputs; priority is `halt`, then data request, then none.
  - `halt`=1 → HALT. No `pcWEN`; PC stays on the HALT instruction.
  - `dREN`|`dWEN` → DATA.
  - Otherwise → COMMIT.
- DATA: `ramaddr`=`daddr`.
  - `ramWEN`=`dWEN`; `ramREN`=`dREN` & ~`dWEN` (write wins).
  - `ramstore`=`dstore`.
  - If both `dREN` and `dWEN` are high in DECODE, set `bus_err` and perform the write only.
  - On `ram_ready`: if read, `dload` <= `ramload`; next state COMMIT.
- COMMIT: `pcWEN`=`commit`=1 for exactly one cycle. Next state FETCH.
- HALT: `halted`=1, all requests 0. Exits only via nRST.

Other rules:

- `dload` holds its last value across non-load instructions.
- `instr` holds until the next successful fetch.
- nRST asserted mid-access (FETCH or DATA) drops the request immediately, with no completion. After reset the sequence restarts at IDLE → FETCH of the reset PC.
- `ram_ready` outside FETCH/DATA is ignored.
- `bus_err` clears only on reset.

## Timing

- `ram_ready` may be combinational in the request cycle, giving zero wait states.
- Per instruction with zero-wait RAM:
  - Non-memory instruction: 3 cycles (FETCH, DECODE, COMMIT).
  - Load/store: 4 cycles.
- Each RAM wait cycle adds one cycle in FETCH or DATA.
- `pcWEN` rises the cycle after the last `ram_ready` (or after DECODE for non-memory instructions). The PC updates on the following edge.
- `instr` is valid from the first cycle of DECODE.
- `dload` is valid from the first cycle of COMMIT.
- First fetch request is issued in cycle 2 after nRST deasserts (IDLE occupies cycle 1).

## Configuration

- Macro: `MEM_SEQ_TIMEOUT_EN`.
- Defined:
  - An 8-bit+ wait counter (width clog2(TIMEOUT+1)) clears on entry to FETCH or DATA.
  - It increments each cycle that `ram_ready` is 0.
  - When it reaches TIMEOUT with `ram_ready` still 0: set `bus_err`, drop the request, go to HALT. No `pcWEN`.
  - `ram_ready` in the same cycle as the counter reaching TIMEOUT counts as success.
- Undefined: no counter; FETCH/DATA wait indefinitely; `bus_err` is set only by simultaneous `dREN`/`dWEN`.

## Test plan

- Reset, then zero-wait RAM with `ramload`=0x00000020 and no data request → `ramREN` high in cycle 2 with `ramaddr`=`pc`; `instr`=0x00000020 in cycle 3; `pcWEN` is a single pulse in cycle 4; next fetch in cycle 5.
- Load with `daddr`=0x100, `ramload`=0xDEADBEEF, and 2 wait states in DATA → `ramREN`=1 with `ramaddr`=0x100 for 3 cycles; `dload`=0xDEADBEEF in COMMIT; exactly one `pcWEN`.
- Store with `dstore`=0x12345678 → `ramWEN`=1, `ramREN`=0, `ramstore`=0x12345678; `dload` unchanged.
- `halt`=1 in DECODE → `halted`=1 permanently; no `pcWEN`; no further RAM requests until nRST.
- nRST pulsed during a FETCH wait → all outputs 0 asynchronously; refetch starts 2 cycles after release; no spurious `pcWEN`.
- With `MEM_SEQ_TIMEOUT_EN` and TIMEOUT=4, `ram_ready` held 0 in FETCH → `bus_err`=1 and HALT after 4 wait cycles; `ram_ready` arriving on cycle 4 → normal DECODE, `bus_err`=0.
